// File: rtl/turbosound_bus_sequencer_if.sv
// PSG-side and CPU-side bus bundle for the turbosound bus sequencer.
// master = the sequencer itself, slave = CPU decoder plus turbosound pair.
interface turbosound_bus_sequencer_if;
    logic       cpu_req;
    logic       cpu_wr;
    logic       cpu_addr;
    logic [7:0] cpu_di;
    logic       cpu_ack;
    logic [7:0] cpu_do;
    logic       ts_bdir;
    logic       ts_bc;
    logic [7:0] ts_di;
    logic [7:0] ts_do;

    modport master (
        input  cpu_req, cpu_wr, cpu_addr, cpu_di, ts_do,
        output cpu_ack, cpu_do, ts_bdir, ts_bc, ts_di
    );

    modport slave (
        output cpu_req, cpu_wr, cpu_addr, cpu_di, ts_do,
        input  cpu_ack, cpu_do, ts_bdir, ts_bc, ts_di
    );
endinterface

// File: rtl/turbosound_bus_sequencer.sv
// Shares the dual-AY PSG bus between CPU port accesses and a mute/init sequence
// that silences both chips and then restores the CPU-visible select/register context.
module turbosound_bus_sequencer #(
    parameter logic [7:0] MIXER_MUTE = 8'h3F,
    parameter bit         AUTO_INIT  = 1'b1
) (
    input  logic CLK,
    input  logic RESET_L,
    input  logic CE,
    input  logic mute_req,
    output logic busy,
    turbosound_bus_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, STROBE = 2'd1, GAP = 2'd2} state_t;

    localparam logic [4:0] LAST_STEP = 5'd21;
    localparam logic [1:0] OP_LATCH  = 2'b11;
    localparam logic [1:0] OP_WRITE  = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b01;
    localparam logic [1:0] OP_IDLE   = 2'b00;

    state_t          state_q, state_d;
    logic [4:0]      step_q, step_d, next_step;
    logic            seq_op_q, seq_op_d;
    logic            pending_q, pending_d;
    logic            seq_run_q, seq_run_d;
    logic [9:0]      op_q, op_d;
    logic            ack_q, ack_d;
    logic [7:0]      do_q, do_d;
    logic            sel_q, sel_d;
    logic [1:0][7:0] shadow_q, shadow_d;
    logic            issue_seq, start_cpu, restart;

    // Returns {bdir, bc, di} for a given sequence step.
    function automatic logic [9:0] seq_op(input logic [4:0] step, input logic sel,
                                          input logic [1:0][7:0] shadow);
        logic       chip;
        logic [4:0] idx;
        logic [9:0] op;
        chip = (step >= 5'd9);
        idx  = chip ? step - 5'd9 : step;
        op   = {OP_IDLE, 8'h00};
        if (step < 5'd18) begin
            case (idx)
                5'd0:    op = {OP_LATCH, 7'h7F, chip};
                5'd1:    op = {OP_LATCH, 8'h07};
                5'd2:    op = {OP_WRITE, MIXER_MUTE};
                5'd3:    op = {OP_LATCH, 8'h08};
                5'd5:    op = {OP_LATCH, 8'h09};
                5'd7:    op = {OP_LATCH, 8'h0A};
                default: op = {OP_WRITE, 8'h00};
            endcase
        end else begin
            // Restore: the chip not selected by the CPU first, so the CPU's chip ends up selected.
            case (step)
                5'd18:   op = {OP_LATCH, 7'h7F, ~sel};
                5'd19:   op = {OP_LATCH, shadow[~sel]};
                5'd20:   op = {OP_LATCH, 7'h7F, sel};
                default: op = {OP_LATCH, shadow[sel]};
            endcase
        end
        return op;
    endfunction

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        seq_op_d  = seq_op_q;
        pending_d = pending_q | mute_req;
        seq_run_d = seq_run_q;
        op_d      = op_q;
        ack_d     = 1'b0;
        do_d      = do_q;
        sel_d     = sel_q;
        shadow_d  = shadow_q;
        issue_seq = 1'b0;
        start_cpu = 1'b0;
        next_step = 5'd0;
        restart   = pending_q | mute_req;

        case (state_q)
            IDLE: begin
                if (restart)
                    issue_seq = 1'b1;
                else if (bus.cpu_req)
                    start_cpu = 1'b1;
            end
            STROBE: begin
                if (CE) begin
                    state_d   = GAP;
                    op_d[9:8] = OP_IDLE;
                    if (!seq_op_q) begin
                        ack_d = 1'b1;
                        if (op_q[9:8] == OP_READ)
                            do_d = bus.ts_do;
                    end
                end
            end
            GAP: begin
                if (seq_op_q && step_q != LAST_STEP) begin
                    issue_seq = 1'b1;
                    next_step = step_q + 5'd1;
                end else if (restart) begin
                    issue_seq = 1'b1;
                end else begin
                    seq_run_d = 1'b0;
                    if (seq_op_q && bus.cpu_req)
                        start_cpu = 1'b1;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue_seq) begin
            state_d  = STROBE;
            seq_op_d = 1'b1;
            step_d   = next_step;
            op_d     = seq_op(next_step, sel_q, shadow_q);
            if (next_step == 5'd0) begin
                pending_d = 1'b0;
                seq_run_d = 1'b1;
            end
        end

        if (start_cpu) begin
            state_d  = STROBE;
            seq_op_d = 1'b0;
            case ({bus.cpu_wr, bus.cpu_addr})
                2'b11: begin
                    op_d = {OP_LATCH, bus.cpu_di};
                    if (bus.cpu_di[7:1] == 7'h7F)
                        sel_d = bus.cpu_di[0];
                    else
                        shadow_d[sel_q] = bus.cpu_di;
                end
                2'b10:   op_d = {OP_WRITE, bus.cpu_di};
                default: op_d = {OP_READ, op_q[7:0]};
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q   <= IDLE;
            step_q    <= 5'd0;
            seq_op_q  <= 1'b0;
            pending_q <= AUTO_INIT;
            seq_run_q <= 1'b0;
            op_q      <= 10'd0;
            ack_q     <= 1'b0;
            do_q      <= 8'h00;
            sel_q     <= 1'b1;
            shadow_q  <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            seq_op_q  <= seq_op_d;
            pending_q <= pending_d;
            seq_run_q <= seq_run_d;
            op_q      <= op_d;
            ack_q     <= ack_d;
            do_q      <= do_d;
            sel_q     <= sel_d;
            shadow_q  <= shadow_d;
        end
    end

    assign bus.ts_bdir = op_q[9];
    assign bus.ts_bc   = op_q[8];
    assign bus.ts_di   = op_q[7:0];
    assign bus.cpu_ack = ack_q;
    assign bus.cpu_do  = do_q;
    assign busy        = pending_q | seq_run_q;
endmodule
